// File: rtl/game_countdown.sv
// game_countdown
// Pre-game countdown: after a start request shows COUNT_START .. 1, each for
// TICK_CYCLES clocks, then raises is_game_on. The displayed digit and game flag
// are only updated on a rising edge of vblnk so the digit never tears mid-frame.
//
// Ports:
//   clk        in   pixel clock
//   rst        in   synchronous active-high reset
//   start      in   single-cycle request to begin the countdown
//   game_over  in   single-cycle request to end the game / abort the countdown
//   vblnk      in   vertical blanking from the VGA timing stream
//   number     out  [2:0] digit to draw (registered, frame-aligned)
//   is_game_on out  high while the game runs (registered, frame-aligned)
//   counting   out  high while the FSM is in COUNTING (registered, not aligned)
module game_countdown #(
  parameter int unsigned CLK_FREQ_HZ = 65_000_000,
  parameter int unsigned TICK_CYCLES = CLK_FREQ_HZ,
  parameter int unsigned COUNT_START = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       game_over,
  input  logic       vblnk,
  output logic [2:0] number,
  output logic       is_game_on,
  output logic       counting
);

  localparam int unsigned PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_CYCLES - 1);
  localparam logic [2:0] DIGIT_START = 3'(COUNT_START);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COUNTING = 2'd1,
    GAME_ON  = 2'd2
  } state_t;

  state_t        r_state;
  logic [PW-1:0] r_presc;
  logic [2:0]    r_digit;
  logic          r_game;
  logic          r_vblnk_prev;
  logic          w_vblnk_rise;

  assign w_vblnk_rise = vblnk & ~r_vblnk_prev;

  // Countdown FSM, prescaler and frame-aligned output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_presc      <= '0;
      r_digit      <= DIGIT_START;
      r_game       <= 1'b0;
      r_vblnk_prev <= 1'b0;
      number       <= DIGIT_START;
      is_game_on   <= 1'b0;
      counting     <= 1'b0;
    end else begin
      r_vblnk_prev <= vblnk;

      // Outputs capture the internal view as it was before this edge's update
      if (w_vblnk_rise) begin
        number     <= r_digit;
        is_game_on <= r_game;
      end

      case (r_state)
        IDLE: begin
          r_digit <= DIGIT_START;
          r_game  <= 1'b0;
          // game_over wins over a simultaneous start
          if (start && !game_over) begin
            r_state  <= COUNTING;
            r_presc  <= '0;
            counting <= 1'b1;
          end
        end

        COUNTING: begin
          if (game_over) begin
            r_state  <= IDLE;
            r_presc  <= '0;
            r_digit  <= DIGIT_START;
            counting <= 1'b0;
          end else if (r_presc == TICK_LAST) begin
            r_presc <= '0;
            if (r_digit > 3'd1) begin
              r_digit <= r_digit - 3'd1;
            end else begin
              r_state  <= GAME_ON;
              r_game   <= 1'b1;
              counting <= 1'b0;
            end
          end else begin
            r_presc <= r_presc + PW'(1);
          end
        end

        GAME_ON: begin
          r_game <= 1'b1;
          if (game_over) begin
            r_state <= IDLE;
            r_digit <= DIGIT_START;
            r_game  <= 1'b0;
          end
        end

        default: begin
          r_state  <= IDLE;
          r_presc  <= '0;
          r_digit  <= DIGIT_START;
          r_game   <= 1'b0;
          counting <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_countdown.sv
// Directed bench for game_countdown with an elapsed-time reference model.
module tb_game_countdown;

  localparam int TICK = 10;
  localparam int CS   = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       game_over = 1'b0;
  logic       vblnk = 1'b0;
  logic [2:0] number;
  logic       is_game_on;
  logic       counting;

  game_countdown #(
    .CLK_FREQ_HZ(TICK),
    .TICK_CYCLES(TICK),
    .COUNT_START(CS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .game_over (game_over),
    .vblnk     (vblnk),
    .number    (number),
    .is_game_on(is_game_on),
    .counting  (counting)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  function automatic void chk(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endfunction

  // Reference model: mode 0=idle 1=counting 2=game; digit derived from elapsed clocks
  int m_mode = 0;
  int m_el   = 0;
  int m_num  = CS;
  int m_game = 0;
  bit m_vprev = 1'b0;

  always @(posedge clk) begin
    int cur;
    if (rst) begin
      m_mode = 0; m_el = 0; m_num = CS; m_game = 0; m_vprev = 1'b0;
    end else begin
      cur = (m_mode == 1) ? CS - m_el / TICK : ((m_mode == 2) ? 1 : CS);
      if (vblnk && !m_vprev) begin
        m_num  = cur;
        m_game = (m_mode == 2) ? 1 : 0;
      end
      m_vprev = vblnk;
      case (m_mode)
        0: if (start && !game_over) begin m_mode = 1; m_el = 0; end
        1: if (game_over) m_mode = 0;
           else begin
             m_el++;
             if (m_el == CS * TICK) m_mode = 2;
           end
        default: if (game_over) m_mode = 0;
      endcase
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("number", int'(number), m_num);
      chk("is_game_on", int'(is_game_on), m_game);
      chk("counting", int'(counting), (m_mode == 1) ? 1 : 0);
    end
  end

  // Stimulus step: advance to next negedge and drive the vblnk pattern
  bit vb_en = 1'b1;
  bit vb_force = 1'b0;
  int vcyc = 0;

  task automatic step();
    @(negedge clk);
    vcyc++;
    vblnk = vb_en ? ((vcyc % 4) < 2) : vb_force;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic pulse_over();
    game_over = 1'b1; step(); game_over = 1'b0;
  endtask

  // Count clocks until counting drops, bounded
  task automatic count_run(output int k);
    k = 0;
    while (counting && k < 100) begin
      step();
      k++;
    end
  endtask

  initial begin
    int k;
    steps(3);
    rst = 1'b0;
    cmp_en = 1'b1;
    step();
    // Reset state
    chk("rst_number", int'(number), 3);
    chk("rst_game", int'(is_game_on), 0);
    chk("rst_counting", int'(counting), 0);
    steps(8);
    chk("idle_number_vblnk", int'(number), 3);

    // Full countdown
    pulse_start();
    chk("count_rise", int'(counting), 1);
    count_run(k);
    chk("count_len", k, 30);
    k = 0;
    while (!is_game_on && k < 10) begin step(); k++; end
    chk("game_on_seen", int'(is_game_on), 1);
    chk("game_on_number", int'(number), 1);
    steps(6);
    pulse_over();
    steps(6);
    chk("over_number", int'(number), 3);
    chk("over_game", int'(is_game_on), 0);

    // Abort at elapsed 15 (digit 2)
    pulse_start();
    steps(14);
    pulse_over();
    chk("abort_counting", int'(counting), 0);
    steps(8);
    chk("abort_number", int'(number), 3);
    chk("abort_game", int'(is_game_on), 0);
    steps(40);

    // Simultaneous start+game_over in IDLE
    start = 1'b1; game_over = 1'b1; step(); start = 1'b0; game_over = 1'b0;
    chk("simul_counting", int'(counting), 0);
    steps(3);

    // Second start during counting does not retime
    pulse_start();
    k = 0;
    while (counting && k < 100) begin
      start = (k == 4);
      step();
      k++;
    end
    start = 1'b0;
    chk("restart_ignored_len", k, 30);
    steps(6);
    pulse_over();
    steps(6);

    // Frame alignment: vblnk held low for 40 clks
    vb_en = 1'b0; vb_force = 1'b0;
    steps(3);
    pulse_start();
    for (int i = 0; i < 40; i++) begin
      step();
      if (i == 12 || i == 25 || i == 39) chk("frozen_number", int'(number), 3);
    end
    vb_force = 1'b1;
    steps(2);
    chk("late_number", int'(number), 1);
    chk("late_game", int'(is_game_on), 1);
    vb_force = 1'b0;
    step();
    vb_en = 1'b1;
    pulse_over();
    steps(8);

    // Reset mid-count at elapsed 17
    pulse_start();
    steps(16);
    rst = 1'b1; step(); rst = 1'b0;
    chk("midrst_counting", int'(counting), 0);
    chk("midrst_number", int'(number), 3);
    chk("midrst_game", int'(is_game_on), 0);
    steps(3);
    pulse_start();
    count_run(k);
    chk("fresh_len", k, 30);
    steps(8);
    chk("fresh_game", int'(is_game_on), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
